// File: rtl/mul_half_precision_seq.sv
`default_nettype none
// ============================================================================
// Module      : mul_half_precision_seq
// Description : Sequential half-precision multiplier. An 11-cycle shift-add
//               loop forms the significand product, a single normalise cycle
//               builds the result, and the result is held until the next start.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_half_precision_seq (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [15:0] i_MultiplicandA,
    input  logic [15:0] i_MultiplierB,
    output logic [15:0] o_Product,
    output logic        o_Exception,
    output logic        o_Busy,
    output logic        o_Done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        NORM = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] c_SATURATE = 16'h7FFF;
    localparam logic [15:0] c_ZERO     = 16'h0000;
    localparam logic [3:0]  c_LAST_BIT = 4'd10;
    localparam logic [6:0]  c_BIAS     = 7'd15;
    localparam logic [6:0]  c_EXP_MAX  = 7'd31;

    state_t      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [21:0] acc_q, acc_d;
    logic [10:0] sig_a_q, sig_a_d;
    logic [10:0] sig_b_q, sig_b_d;
    logic [4:0]  exp_a_q, exp_a_d;
    logic [4:0]  exp_b_q, exp_b_d;
    logic        sign_q, sign_d;
    logic [15:0] product_q, product_d;
    logic        exception_q, exception_d;

    // Operand field decode, used only in IDLE when a start is accepted
    logic [4:0]  w_exp_a_in;
    logic [4:0]  w_exp_b_in;
    logic        w_special_in;
    logic        w_zero_in;

    // Normalisation results, meaningful only while in NORM
    logic        w_norm;
    logic [9:0]  w_mant;
    logic [6:0]  w_exp;
    logic        w_underflow;
    logic        w_overflow;

    // Decode incoming exponent fields for the infinity/NaN and zero shortcuts
    always_comb begin
        w_exp_a_in   = i_MultiplicandA[14:10];
        w_exp_b_in   = i_MultiplierB[14:10];
        w_special_in = (w_exp_a_in == 5'd31) || (w_exp_b_in == 5'd31);
        w_zero_in    = (w_exp_a_in == 5'd0)  || (w_exp_b_in == 5'd0);
    end

    // Normalise the 22-bit significand product and form the signed exponent
    always_comb begin
        w_norm      = acc_q[21];
        w_mant      = w_norm ? acc_q[20:11] : acc_q[19:10];
        // Two's-complement in 7 bits: range is -13..46, so bit 6 is the sign
        w_exp       = {2'b00, exp_a_q} + {2'b00, exp_b_q}
                      + {6'b000000, w_norm} - c_BIAS;
        w_underflow = w_exp[6] || (w_exp == 7'd0);
        w_overflow  = !w_exp[6] && (w_exp >= c_EXP_MAX);
    end

    // Next-state, datapath and result computation
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        acc_d       = acc_q;
        sig_a_d     = sig_a_q;
        sig_b_d     = sig_b_q;
        exp_a_d     = exp_a_q;
        exp_b_d     = exp_b_q;
        sign_d      = sign_q;
        product_d   = product_q;
        exception_d = exception_q;

        case (state_q)
            IDLE: begin
                if (i_Start) begin
                    sign_d  = i_MultiplicandA[15] ^ i_MultiplierB[15];
                    exp_a_d = w_exp_a_in;
                    exp_b_d = w_exp_b_in;
                    sig_a_d = {1'b1, i_MultiplicandA[9:0]};
                    sig_b_d = {1'b1, i_MultiplierB[9:0]};
                    count_d = 4'd0;
                    acc_d   = 22'd0;
                    // All-ones exponent outranks zero
                    if (w_special_in) begin
                        product_d   = c_SATURATE;
                        exception_d = 1'b1;
                        state_d     = DONE;
                    end else if (w_zero_in) begin
                        product_d   = c_ZERO;
                        exception_d = 1'b0;
                        state_d     = DONE;
                    end else begin
                        state_d     = MULT;
                    end
                end
            end
            MULT: begin
                if (sig_b_q[count_q]) begin
                    acc_d = acc_q + ({11'd0, sig_a_q} << count_q);
                end
                if (count_q == c_LAST_BIT) begin
                    count_d = 4'd0;
                    state_d = NORM;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end
            NORM: begin
                if (w_overflow) begin
                    product_d   = c_SATURATE;
                    exception_d = 1'b1;
                end else if (w_underflow) begin
                    product_d   = c_ZERO;
                    exception_d = 1'b1;
                end else begin
                    product_d   = {sign_q, w_exp[4:0], w_mant};
                    exception_d = 1'b0;
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q     <= IDLE;
            count_q     <= 4'd0;
            acc_q       <= 22'd0;
            sig_a_q     <= 11'd0;
            sig_b_q     <= 11'd0;
            exp_a_q     <= 5'd0;
            exp_b_q     <= 5'd0;
            sign_q      <= 1'b0;
            product_q   <= 16'h0000;
            exception_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            sig_a_q     <= sig_a_d;
            sig_b_q     <= sig_b_d;
            exp_a_q     <= exp_a_d;
            exp_b_q     <= exp_b_d;
            sign_q      <= sign_d;
            product_q   <= product_d;
            exception_q <= exception_d;
        end
    end

    // Status outputs decode directly from the registered state
    always_comb begin
        o_Product   = product_q;
        o_Exception = exception_q;
        o_Busy      = (state_q != IDLE);
        o_Done      = (state_q == DONE);
    end

endmodule
`default_nettype wire

// File: doc/mul_half_precision_seq.md
MUL_HALF_PRECISION_SEQ -- requirements
Module: mul_half_precision_seq

Interface
REQ-001 Single clock; reset is asynchronous and active-high; the clock port is i_Clk and the reset port is i_Reset.
REQ-002 i_Clk  input  1  clock; all state updates on its rising edge.
REQ-003 i_Reset  input  1  asynchronous, active-high reset.
REQ-004 i_Start  input  1  request to start a multiply; sampled only in IDLE.
REQ-005 i_MultiplicandA  input  16  operand A, half precision (sign[15], exp[14:10] bias 15, mantissa[9:0]).
REQ-006 i_MultiplierB  input  16  operand B, same format.
REQ-007 o_Product  output  16  registered result, held until the next accepted start.
REQ-008 o_Exception  output  1  overflow/underflow flag for o_Product; held with o_Product.
REQ-009 o_Busy  output  1  high from the cycle after start acceptance through the o_Done cycle inclusive.
REQ-010 o_Done  output  1  one-cycle pulse marking o_Product/o_Exception valid.

Function
REQ-011 FSM states SHALL be IDLE, MULT, NORM, DONE; DONE always returns to IDLE on the next edge.
REQ-012 In IDLE, an edge with i_Start=1 SHALL latch both operands and the sign XOR, then go to MULT; the special cases of REQ-013/014 go straight to DONE instead.
REQ-013 Special case: if either exponent field is 31, the next state SHALL be DONE with o_Product=16'h7FFF and o_Exception=1; this has priority over zero.
REQ-014 Zero case: if either exponent field is 0, the operand is treated as zero (denormals flushed), the next state SHALL be DONE, o_Product=16'h0000 and o_Exception=0.
REQ-015 MULT SHALL run exactly 11 cycles of shift-add on 11-bit significands {1,mant}, using a 4-bit counter 0..10.
REQ-016 Each MULT cycle SHALL add (significand A << count) into a 22-bit accumulator when bit[count] of significand B is 1.
REQ-017 NORM (1 cycle), with P the 22-bit product: if P[21]=1, mantissa=P[20:11] and norm=1; otherwise mantissa=P[19:10] and norm=0.
REQ-018 Truncation only; no rounding.
REQ-019 The exponent SHALL be computed as a signed 7-bit value: E = EA + EB - 15 + norm.
REQ-020 If E >= 31: o_Product=16'h7FFF, o_Exception=1.
REQ-021 If E <= 0: o_Product=16'h0000, o_Exception=1.
REQ-022 Otherwise: o_Product={sign,E[4:0],mantissa}, o_Exception=0.
REQ-023 o_Product and o_Exception SHALL update on the edge that enters DONE; o_Done is high only while in DONE.
REQ-024 Latency: for normal operands, o_Done SHALL be high in the 13th cycle after the accepting edge (11 MULT + 1 NORM + DONE); for special/zero operands, in the cycle right after it.
REQ-025 i_Start SHALL be ignored in MULT, NORM and DONE; operand changes after acceptance SHALL NOT affect the result.
REQ-026 Back-to-back: a start asserted during DONE SHALL be ignored; it is accepted on the next IDLE edge.

Reset
REQ-027 i_Reset=1 SHALL force, asynchronously: state=IDLE, counter=0, accumulator=0, o_Product=16'h0000, o_Exception=0, o_Busy=0, o_Done=0.
REQ-028 Reset mid-operation SHALL abort with no o_Done pulse; the first start after reset release SHALL operate normally.

Verification
REQ-029 Basic multiply: A=0x3C00, B=0x4000, start -> o_Product=0x4000, o_Exception=0, o_Done exactly one cycle, 13 cycles after accept, o_Busy high for 13 cycles.
REQ-030 Normalization and sign: 0x3E00*0x3E00 -> 0x4080 (P[21]=1 path); 0xC000*0x4200 -> 0xC600.
REQ-031 Overflow and underflow: 0x7800*0x7800 -> 0x7FFF, exc=1; 0x0400*0x3800 -> 0x0000, exc=1 (E=0).
REQ-032 Shortcuts: 0x0000*0x4000 -> 0x0000, exc=0; 0x7C00*0x0000 -> 0x7FFF, exc=1; both with o_Done in the cycle after accept.
REQ-033 Protocol: start held high plus operand changes during MULT -> the first result is unaffected, and the second start is accepted only after DONE->IDLE.
REQ-034 Reset mid-operation: i_Reset pulsed at MULT cycle 5 -> all outputs 0 immediately and no o_Done; the following multiply 0x3C00*0x3C00 -> 0x3C00.
